// File: rtl/rm14_pkg.sv
// ---------------------------------------------------------------------------
// rm14_pkg
// Shared widths, FSM state encoding and a small helper for the RM(1,4)
// error-book decode controller.
// Contents:
//   CW_W / MSG_W / SYN_W  codeword, message and syndrome widths (16, 5, 11)
//   STAT_W                statistics counter width
//   state_e               controller FSM states IDLE, SEARCH, DONE
//   sat_inc()             saturating +1 for the statistics counters
// ---------------------------------------------------------------------------
package rm14_pkg;

  localparam int CW_W   = 16;
  localparam int MSG_W  = 5;
  localparam int SYN_W  = 11;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/rm14_syndrome.sv
// ---------------------------------------------------------------------------
// rm14_syndrome
// Combinational 16-to-11 syndrome of a received RM(1,4) word.
// Ports:
//   word_i  [16] received word, bit 15 = codeword bit b0 ... bit 0 = b15
//   syn_o   [11] syndrome s0..s10, s0 in bit 10
// ---------------------------------------------------------------------------
module rm14_syndrome
  import rm14_pkg::*;
(
  input  logic [CW_W-1:0]  word_i,
  output logic [SYN_W-1:0] syn_o
);

  // b[i] is codeword bit bi; the port carries b0 in its MSB.
  logic [CW_W-1:0] b;

  always_comb begin
    for (int i = 0; i < CW_W; i++) begin
      b[i] = word_i[CW_W-1-i];
    end
  end

  // Each check covers one parity bit (b5..b15) plus its message-bit subset.
  assign syn_o = {
    b[0] ^ b[1] ^ b[2] ^ b[5],                 // s0
    b[0] ^ b[1] ^ b[3] ^ b[6],                 // s1
    b[0] ^ b[1] ^ b[4] ^ b[7],                 // s2
    b[0] ^ b[2] ^ b[3] ^ b[8],                 // s3
    b[0] ^ b[2] ^ b[4] ^ b[9],                 // s4
    b[0] ^ b[3] ^ b[4] ^ b[10],                // s5
    b[1] ^ b[2] ^ b[3] ^ b[11],                // s6
    b[1] ^ b[2] ^ b[4] ^ b[12],                // s7
    b[1] ^ b[3] ^ b[4] ^ b[13],                // s8
    b[2] ^ b[3] ^ b[4] ^ b[14],                // s9
    b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[15]   // s10
  };

endmodule

// File: rtl/rm14_decode_ctrl.sv
// ---------------------------------------------------------------------------
// rm14_decode_ctrl
// Error-book decode controller for a 16-bit RM(1,4) word. A received word is
// registered, its syndrome is computed, and on a nonzero syndrome the external
// error book is scanned linearly (one entry per cycle, 1-cycle read latency)
// until the first stored syndrome that matches. The matching error pattern is
// XORed onto the message bits.
//
// Optional feature (macro RM14_STATS_EN): decoded / corrected / uncorrectable
// result counters, saturating, cleared by stat_clr. Without the macro the
// stat_* outputs are tied to zero and stat_clr is ignored.
//
// Parameters: TABLE_DEPTH entries searched, ADDR_W error-book address width.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready / r_in received-word handshake (ready only in IDLE)
//   rom_en / rom_addr          error-book read strobe and index
//   rom_eb / rom_e             stored syndrome / error pattern, 1 cycle later
//   out_valid / out_ready      result handshake
//   message, syndrome          corrected b0..b4 (b0 in bit 4), s0..s10
//   err_found, uncorrectable   match found / nonzero syndrome without match
//   stat_clr, stat_words, stat_corr, stat_fail  statistics
// ---------------------------------------------------------------------------
module rm14_decode_ctrl
  import rm14_pkg::*;
#(
  parameter int TABLE_DEPTH = 697,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   r_in,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [SYN_W-1:0]  rom_eb,
  input  logic [CW_W-1:0]   rom_e,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MSG_W-1:0]  message,
  output logic [SYN_W-1:0]  syndrome,
  output logic              err_found,
  output logic              uncorrectable,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_words,
  output logic [STAT_W-1:0] stat_corr,
  output logic [STAT_W-1:0] stat_fail
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TABLE_DEPTH - 1);

  state_e             state_q, state_d;
  logic [CW_W-1:0]    word_q, word_d;
  // Only the message part of the error pattern can reach an output.
  logic [MSG_W-1:0]   err_msg_q, err_msg_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               issue_done_q, issue_done_d;  // last address issued
  logic               rd_valid_q, rd_valid_d;      // rom_eb/rom_e valid now
  logic               rd_last_q, rd_last_d;        // ... and it is the last entry
  logic               found_q, found_d;
  logic               unc_q, unc_d;

  logic [SYN_W-1:0]   syn;
  logic               match;
  logic               unused_rom_e_lo;

  rm14_syndrome u_syndrome (
    .word_i (word_q),
    .syn_o  (syn)
  );

  assign match           = rd_valid_q && (rom_eb == syn);
  assign unused_rom_e_lo = ^rom_e[CW_W-MSG_W-1:0];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the value.
    state_d      = state_q;
    word_d       = word_q;
    err_msg_d    = err_msg_q;
    addr_d       = addr_q;
    issue_done_d = issue_done_q;
    rd_valid_d   = 1'b0;
    rd_last_d    = 1'b0;
    found_d      = found_q;
    unc_d        = unc_q;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    rom_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d       = r_in;
          err_msg_d    = '0;
          addr_d       = '0;
          issue_done_d = 1'b0;
          found_d      = 1'b0;
          unc_d        = 1'b0;
          state_d      = SEARCH;
        end
      end

      SEARCH: begin
        if (syn == '0) begin
          // Clean word: no error-book traffic, pattern stays zero.
          state_d = DONE;
        end else begin
          if (!issue_done_q) begin
            rom_en     = 1'b1;
            rd_valid_d = 1'b1;
            rd_last_d  = (addr_q == LAST_ADDR);
            if (addr_q == LAST_ADDR) issue_done_d = 1'b1;
            else                     addr_d       = addr_q + ADDR_W'(1);
          end
          // A read issued in the same cycle as the match is simply dropped.
          if (match) begin
            err_msg_d = rom_e[CW_W-1 -: MSG_W];
            found_d   = 1'b1;
            state_d   = DONE;
          end else if (rd_valid_q && rd_last_q) begin
            unc_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_q       <= '0;
      err_msg_q    <= '0;
      addr_q       <= '0;
      issue_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      found_q      <= 1'b0;
      unc_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      word_q       <= word_d;
      err_msg_q    <= err_msg_d;
      addr_q       <= addr_d;
      issue_done_q <= issue_done_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      found_q      <= found_d;
      unc_q        <= unc_d;
    end
  end

  assign rom_addr      = addr_q;
  assign message       = word_q[CW_W-1 -: MSG_W] ^ err_msg_q;
  assign syndrome      = syn;
  assign err_found     = found_q;
  assign uncorrectable = unc_q;

`ifdef RM14_STATS_EN
  logic              result_hs;
  logic [STAT_W-1:0] words_q, corr_q, fail_q;

  assign result_hs = out_valid && out_ready;

  // Clear wins over an increment landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
      corr_q  <= '0;
      fail_q  <= '0;
    end else if (stat_clr) begin
      words_q <= '0;
      corr_q  <= '0;
      fail_q  <= '0;
    end else if (result_hs) begin
      words_q <= sat_inc(words_q);
      if (found_q) corr_q <= sat_inc(corr_q);
      if (unc_q)   fail_q <= sat_inc(fail_q);
    end
  end

  assign stat_words = words_q;
  assign stat_corr  = corr_q;
  assign stat_fail  = fail_q;
`else
  logic unused_stat_clr;

  assign unused_stat_clr = stat_clr;
  assign stat_words      = '0;
  assign stat_corr       = '0;
  assign stat_fail       = '0;
`endif

endmodule

// File: tb/tb_rm14_decode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rm14_decode_ctrl
// Self-checking bench for rm14_decode_ctrl (TABLE_DEPTH=8, ADDR_W=4). A small
// behavioural error book answers reads one cycle after rom_en. Expected
// results come from a bench-side syndrome/search model, are queued when a word
// is driven and popped when the DUT presents its result.
// Statistics expectations follow the RM14_STATS_EN macro.
// ---------------------------------------------------------------------------
module tb_rm14_decode_ctrl;

  localparam int D  = 8;
  localparam int AW = 4;

`ifdef RM14_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [4:0]  msg;
    logic [10:0] syn;
    logic        found;
    logic        unc;
    int          lat;
    int          issued;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   r_in = '0;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [10:0]   rom_eb = '0;
  logic [15:0]   rom_e = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [4:0]    message;
  logic [10:0]   syndrome;
  logic          err_found;
  logic          uncorrectable;
  logic          stat_clr = 1'b0;
  logic [15:0]   stat_words, stat_corr, stat_fail;

  logic [10:0]   tbl_eb [D];
  logic [15:0]   tbl_e  [D];
  // Bit i of mask j selects codeword bit bi into syndrome bit sj.
  logic [15:0]   syn_mask [11] = '{16'h0027, 16'h004B, 16'h0093, 16'h010D,
                                   16'h0215, 16'h0419, 16'h080E, 16'h1016,
                                   16'h201A, 16'h401C, 16'h801F};

  exp_t sb [$];
  int   checks   = 0;
  int   failures = 0;

  rm14_decode_ctrl #(.TABLE_DEPTH(D), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .r_in          (r_in),
    .rom_en        (rom_en),
    .rom_addr      (rom_addr),
    .rom_eb        (rom_eb),
    .rom_e         (rom_e),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .message       (message),
    .syndrome      (syndrome),
    .err_found     (err_found),
    .uncorrectable (uncorrectable),
    .stat_clr      (stat_clr),
    .stat_words    (stat_words),
    .stat_corr     (stat_corr),
    .stat_fail     (stat_fail)
  );

  always #5 clk = ~clk;

  // Error book: data for the address strobed on this edge appears after it.
  always @(posedge clk) begin
    if (rom_en) begin
      rom_eb <= tbl_eb[rom_addr[2:0]];
      rom_e  <= tbl_e[rom_addr[2:0]];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] model_syn(input logic [15:0] w);
    logic [15:0] bv;
    logic [10:0] s;
    for (int i = 0; i < 16; i++) bv[i] = w[15-i];
    for (int j = 0; j < 11; j++) s[10-j] = ^(bv & syn_mask[j]);
    return s;
  endfunction

  function automatic logic [15:0] codeword(input logic [4:0] m);
    logic [15:0] t;
    t = {m, 11'b0};
    return t | {5'b0, model_syn(t)};
  endfunction

  function automatic exp_t model(input logic [15:0] w);
    exp_t        e;
    logic [15:0] pat;
    logic [15:0] corr;
    int          k;
    pat      = '0;
    k        = -1;
    e.syn    = model_syn(w);
    e.found  = 1'b0;
    e.unc    = 1'b0;
    if (e.syn == '0) begin
      e.lat    = 2;
      e.issued = 0;
    end else begin
      for (int i = 0; i < D; i++) if (k < 0 && tbl_eb[i] == e.syn) k = i;
      if (k >= 0) begin
        e.found  = 1'b1;
        pat      = tbl_e[k];
        e.lat    = 3 + k;
        e.issued = (k + 2 > D) ? D : k + 2;
      end else begin
        e.unc    = 1'b1;
        e.lat    = D + 2;
        e.issued = D;
      end
    end
    corr  = w ^ pat;
    e.msg = corr[15:11];
    return e;
  endfunction

  function automatic void load_default_table();
    for (int i = 0; i < D; i++) begin
      tbl_e[i]  = 16'h0001 << i;
      tbl_eb[i] = model_syn(tbl_e[i]);
    end
  endfunction

  // Drive one word, follow its search, check the result, optionally stall the
  // consumer for `hold` cycles (with a competing in_valid), then hand it off.
  task automatic do_word(input logic [15:0] w, input int hold, input bit clr_at_hs);
    exp_t e;
    int   n;
    int   issued;
    sb.push_back(model(w));
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    r_in     = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    r_in     = 16'($urandom);
    n        = 1;
    issued   = 0;
    while (!out_valid && n < 40) begin
      if (rom_en) begin
        check("rom_addr_seq", rom_addr, issued);
        issued++;
      end
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    check("out_valid", out_valid, 1);
    check("latency", n, e.lat);
    check("rom_issued", issued, e.issued);
    check("message", message, e.msg);
    check("syndrome", syndrome, e.syn);
    check("err_found", err_found, e.found);
    check("uncorrectable", uncorrectable, e.unc);
    check("rom_en_done", rom_en, 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      r_in     = 16'hFFFF;
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_message", message, e.msg);
      check("hold_syndrome", syndrome, e.syn);
      check("hold_err_found", err_found, e.found);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    stat_clr  = clr_at_hs;
    check("handover_in_ready", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    stat_clr  = 1'b0;
    in_valid  = 1'b0;
    check("after_hs_valid", out_valid, 0);
    check("after_hs_ready", in_ready, 1);
  endtask

  task automatic check_stats(input string tag, input int w, input int c, input int f);
    check({tag, "_words"}, stat_words, STATS ? w : 0);
    check({tag, "_corr"},  stat_corr,  STATS ? c : 0);
    check({tag, "_fail"},  stat_fail,  STATS ? f : 0);
  endtask

  initial begin
    int n;
    load_default_table();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_rom_en", rom_en, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_message", message, 0);
    check("rst_syndrome", syndrome, 0);
    check("rst_err_found", err_found, 0);
    check("rst_unc", uncorrectable, 0);
    check_stats("rst", 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", in_ready, 1);

    // Clean word: direct to DONE, no error-book reads
    do_word(16'h0000, 0, 1'b0);

    // Single match at entry 5
    tbl_eb[5] = 11'b11111100001;
    tbl_e[5]  = 16'h8000;
    do_word(16'h8000, 0, 1'b0);

    // Same word, no entry matches: full scan, uncorrectable
    load_default_table();
    do_word(16'h8000, 0, 1'b0);
    check_stats("three", 3, 1, 1);

    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check_stats("clr", 0, 0, 0);

    // Parity-bit errors on valid codewords: match at every table index,
    // including the last one
    for (int i = 0; i < D; i++) begin
      do_word(codeword(5'($urandom_range(0, 31))) ^ (16'h0001 << i), 0, 1'b0);
    end
    check_stats("par", D, D, 0);

    // Arbitrary words
    for (int i = 0; i < 6; i++) do_word(16'($urandom), 0, 1'b0);

    // Consumer stall with a competing input word
    do_word(16'h0001, 5, 1'b0);

    // Clear coinciding with a result handshake
    do_word(16'h8000, 0, 1'b1);
    check_stats("clr_prio", 0, 0, 0);
    do_word(codeword(5'b10110), 0, 1'b0);
    check_stats("after_prio", 1, 0, 0);

    // Reset in the middle of a search
    in_valid = 1'b1;
    r_in     = 16'h8000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!(rom_en && rom_addr == AW'(3)) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_search_idx", rom_addr, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rom_en", rom_en, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_rom_addr", rom_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_in_ready", in_ready, 1);
    check("mid_rel_out_valid", out_valid, 0);
    check("mid_rel_err_found", err_found, 0);
    do_word(codeword(5'b01011) ^ 16'h0004, 0, 1'b0);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rm14_decode_ctrl.md
RM14_DECODE_CTRL -- requirements
Module: rm14_decode_ctrl

Interface
REQ-001 SHALL have parameter TABLE_DEPTH, default 697: number of error-book entries searched.
REQ-002 SHALL have parameter ADDR_W, default 10: error-book address width; TABLE_DEPTH <= 2^ADDR_W.
REQ-003 SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  received word valid.
REQ-007 in_ready  out  1  controller can accept a word.
REQ-008 r_in  in  16  received word; bit 15 = codeword bit b0 ... bit 0 = b15.
REQ-009 rom_en  out  1  error-book read strobe.
REQ-010 rom_addr  out  ADDR_W  error-book index.
REQ-011 rom_eb  in  11  stored syndrome for the index; valid one cycle after rom_en.
REQ-012 rom_e  in  16  stored error pattern for the index; same timing as rom_eb.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 message  out  5  corrected b0..b4, with b0 in bit 4.
REQ-016 syndrome  out  11  s0..s10 of the registered word, with s0 in bit 10.
REQ-017 err_found  out  1  a nonzero syndrome matched an entry.
REQ-018 uncorrectable  out  1  nonzero syndrome with no match.
REQ-019 stat_clr  in  1  clear the statistics counters.
REQ-020 stat_words, stat_corr, stat_fail  out  16 each  decoded, corrected and uncorrectable word counts.

Function
REQ-021 Syndrome bits SHALL be XORs of the bits listed:
- s0 = b0 b1 b2 b5
- s1 = b0 b1 b3 b6
- s2 = b0 b1 b4 b7
- s3 = b0 b2 b3 b8
- s4 = b0 b2 b4 b9
- s5 = b0 b3 b4 b10
- s6 = b1 b2 b3 b11
- s7 = b1 b2 b4 b12
- s8 = b1 b3 b4 b13
- s9 = b2 b3 b4 b14
- s10 = b0 b1 b2 b3 b4 b15
REQ-022 The FSM SHALL have the states IDLE, SEARCH and DONE.
REQ-023 in_ready SHALL be 1 only in IDLE; when in_valid=1 in IDLE, r_in SHALL be registered at cycle T and the FSM SHALL leave IDLE.
REQ-024 At T+1 with syndrome=0, the FSM SHALL go to DONE with error pattern 0 and err_found=0, giving out_valid at T+2.
REQ-025 At T+1 with syndrome nonzero, the FSM SHALL enter SEARCH and issue rom_en=1, rom_addr=0; the address SHALL increment by 1 each cycle.
REQ-026 The compare of entry k SHALL occur at T+2+k; the first match wins, latches rom_e, sets err_found=1 and gives out_valid at T+3+k.
REQ-027 An address issued after the match SHALL be discarded.
REQ-028 No match after entry TABLE_DEPTH-1 SHALL give uncorrectable=1, error pattern 0 and out_valid at T+TABLE_DEPTH+2.
REQ-029 rom_en SHALL be 0 outside SEARCH, and rom_addr SHALL never exceed TABLE_DEPTH-1.
REQ-030 message SHALL equal bits b0..b4 of (registered word XOR latched error pattern).
REQ-031 In DONE, out_valid, message, syndrome, err_found and uncorrectable SHALL hold stable until out_valid & out_ready, then the FSM SHALL return to IDLE.
REQ-032 No new word SHALL be accepted in the DONE/IDLE handover cycle.

Reset
REQ-033 When rst_n=0, the FSM SHALL go to IDLE at any state, including mid-SEARCH; the in-flight word SHALL be discarded with no output.
REQ-034 Reset values: in_ready=1 after release; out_valid, rom_en, err_found, uncorrectable = 0; rom_addr, message, syndrome, registered word, error pattern = 0; stat_* = 0.

Configuration
REQ-035 With RM14_STATS_EN defined, at each result handshake:
- stat_words SHALL increment;
- stat_corr SHALL increment if err_found=1;
- stat_fail SHALL increment if uncorrectable=1;
- all three SHALL saturate at 16'hFFFF.
REQ-036 With RM14_STATS_EN defined, stat_clr SHALL zero all counters in the next cycle and SHALL take priority over a simultaneous increment.
REQ-037 Without RM14_STATS_EN, the stat_* ports SHALL exist, be tied to 0, and stat_clr SHALL be ignored.

Structure
REQ-038 Package rm14_pkg SHALL hold the codeword, message and syndrome widths (16, 5, 11) and the FSM state enum.
REQ-039 Sub-module rm14_syndrome SHALL compute the combinational 16-to-11 syndrome of REQ-021.

Verification
REQ-040 r_in=16'h0000 accepted at T -> out_valid at T+2, message=5'b00000, syndrome=0, err_found=0, no rom_en pulse.
REQ-041 r_in=16'h8000, model entry 5 = {eb=11'b11111100001, e=16'h8000} -> rom_addr 0..6, out_valid at T+8, message=0, err_found=1.
REQ-042 TABLE_DEPTH=8 with no matching entry, r_in=16'h8000 -> out_valid at T+10, uncorrectable=1, message=5'b10000.
REQ-043 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0, the second in_valid is not accepted until after the handshake.
REQ-044 rst_n pulsed low at search index 3 -> rom_en=0 and out_valid=0 immediately, then in_ready=1 after release.
REQ-045 With RM14_STATS_EN: words 16'h0000, 16'h8000 (match), 16'h8000 (no match) -> stat_words=3, stat_corr=1, stat_fail=1; stat_clr -> all 0.
